// File: rtl/acc_step_ctrl_pkg.sv
// acc_step_ctrl_pkg: shared FSM encoding, LEDR bit map and defaults for the accumulator step controller
package acc_step_ctrl_pkg;
  localparam int DEBOUNCE_DEFAULT = 50000;
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_EXEC     = 2'd2,
    ST_WAIT_REL = 2'd3
  } state_t;
  localparam int LED_ACC_LSB = 0;
  localparam int LED_CARRY   = 4;
  localparam int LED_OVF     = 5;
  localparam int LED_CNT_LSB = 6;
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction
endpackage

// File: rtl/acc_step_ctrl_adder.sv
// ripple_add4: ripple-carry adder built from full-adder cells
//   a, b : operands, ci : carry in, s : sum, co : carry out
module full_add_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_add4 #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  logic [N:0] c;
  assign c[0] = ci;
  assign co   = c[N];
  for (genvar i = 0; i < N; i++) begin : g_fa
    full_add_cell u_fa (.a(a[i]), .b(b[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
endmodule

// File: rtl/acc_step_ctrl_debounce.sv
// key_debounce: synchronizes an active-low key, qualifies a stable press, and emits a one-cycle press pulse
//   clk, rst : clock and sync active-high reset
//   key_n    : raw active-low key, asynchronous to clk
//   abort    : forces the FSM out of any press in progress (used for clear)
//   press    : one-cycle pulse in the execute cycle
//   held     : synchronized active-high key level
module key_debounce
  import acc_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  input  logic abort,
  output logic press,
  output logic held
);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  state_t state, nxt;
  assign held = ~sync[1];
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= 2'b11;
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], key_n};
      state <= nxt;
      cnt   <= (state == ST_DEBOUNCE && nxt == ST_DEBOUNCE) ? cnt + CW'(1) : '0;
    end
  end
  always_comb begin
    nxt = state;
    if (abort) nxt = held ? ST_WAIT_REL : ST_IDLE;
    else
      case (state)
        ST_IDLE:     nxt = held ? ST_DEBOUNCE : ST_IDLE;
        ST_DEBOUNCE: nxt = !held ? ST_IDLE : (cnt == LAST) ? ST_EXEC : ST_DEBOUNCE;
        ST_EXEC:     nxt = ST_WAIT_REL;
        default:     nxt = held ? ST_WAIT_REL : ST_IDLE;
      endcase
  end
  always_comb press = (state == ST_EXEC);
endmodule

// File: rtl/acc_step_ctrl.sv
// acc_step_ctrl: debounced-key accumulator around the ripple adder, result and flags on LEDR
//   CLOCK_50 : clock, reset : sync active-high
//   SW[3:0] operand, SW[8] subtract, SW[9] add carry-in
//   KEY[0] step, KEY[1] clear (active-low, asynchronous)
//   LEDR[3:0] acc, [4] carry, [5] sticky signed overflow, [9:6] op count
module acc_step_ctrl
  import acc_step_ctrl_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [9:0] SW,
  input  logic [1:0] KEY,
  output logic [9:0] LEDR
);
  logic [WIDTH-1:0] acc, b_op, sum;
  logic carry, ovf, co, ci, press, clr;
  logic [3:0] cnt;
  logic [1:0] csync;
  logic sw_unused;
  assign sw_unused = ^SW[7:4];
  assign clr = ~csync[1];
  // Subtraction is acc + ~B + 1, so the adder carry-in is forced high and SW[9] ignored.
  assign b_op = SW[8] ? ~SW[WIDTH-1:0] : SW[WIDTH-1:0];
  assign ci   = SW[8] | SW[9];
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .clk(CLOCK_50), .rst(reset), .key_n(KEY[0]), .abort(clr), .press(press), .held()
  );
  ripple_add4 #(.N(WIDTH)) u_add (.a(acc), .b(b_op), .ci(ci), .s(sum), .co(co));
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      csync <= 2'b11;
      acc   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      csync <= {csync[0], KEY[1]};
      if (clr) begin
        acc   <= '0;
        carry <= 1'b0;
        ovf   <= 1'b0;
        cnt   <= '0;
      end else if (press) begin
        acc   <= sum;
        carry <= co;
        ovf   <= ovf | signed_ovf(acc[WIDTH-1], b_op[WIDTH-1], sum[WIDTH-1]);
        cnt   <= cnt + 4'd1;
      end
    end
  end
  assign LEDR[LED_ACC_LSB +: WIDTH] = acc;
  assign LEDR[LED_CARRY]            = carry;
  assign LEDR[LED_OVF]              = ovf;
  assign LEDR[LED_CNT_LSB +: 4]     = cnt;
endmodule

// File: tb/tb_acc_step_ctrl.sv
// tb_acc_step_ctrl: directed scoreboard bench for acc_step_ctrl with a short debounce window
module tb_acc_step_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [9:0] SW = '0;
  logic [1:0] KEY = 2'b11;
  logic [9:0] LEDR;
  typedef struct {
    logic [9:0] v;
    string      n;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  acc_step_ctrl #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50(clk), .reset(reset), .SW(SW), .KEY(KEY), .LEDR(LEDR)
  );

  always @(negedge clk)
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (LEDR !== e.v) begin
        n_bad++;
        $display("FAIL %s: LEDR=%h expected %h", e.n, LEDR, e.v);
      end
    end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_led(input logic [9:0] v, input string n);
    sb.push_back('{v: v, n: n});
  endtask

  task automatic press(input int n);
    KEY[0] = 1'b0;
    tick(n);
    KEY[0] = 1'b1;
    tick(8);
  endtask

  task automatic clear();
    KEY[1] = 1'b0;
    tick(3);
    KEY[1] = 1'b1;
    tick(4);
  endtask

  initial begin
    tick(2);
    expect_led(10'h000, "reset");
    reset = 1'b0;
    tick(20);
    expect_led(10'h000, "idle");
    SW = 10'h003;
    KEY[0] = 1'b0;
    tick(9);
    expect_led(10'h043, "held_once");
    tick(1);
    KEY[0] = 1'b1;
    tick(8);
    expect_led(10'h043, "step1");
    KEY[0] = 1'b0; tick(2);
    KEY[0] = 1'b1; tick(1);
    KEY[0] = 1'b0; tick(2);
    KEY[0] = 1'b1; tick(10);
    expect_led(10'h043, "bounce");
    SW = 10'h00F; press(10);
    expect_led(10'h092, "add_carry");
    SW = 10'h103; press(10);
    expect_led(10'h0CF, "sub");
    clear();
    expect_led(10'h000, "clear");
    SW = 10'h007; press(10);
    expect_led(10'h047, "add7");
    SW = 10'h001; press(10);
    expect_led(10'h0A8, "ovf_set");
    SW = 10'h000; press(10);
    expect_led(10'h0E8, "ovf_sticky");
    clear();
    SW = 10'h200; press(10);
    expect_led(10'h041, "cin");
    SW = 10'h300; press(10);
    expect_led(10'h091, "sub_ignore_cin");
    SW = 10'h005;
    KEY[0] = 1'b0;
    tick(5);
    KEY[1] = 1'b0;
    tick(1);
    KEY[1] = 1'b1;
    tick(2);
    expect_led(10'h000, "clear_in_exec");
    tick(2);
    KEY[0] = 1'b1;
    tick(8);
    expect_led(10'h000, "clear_discard");
    SW = 10'h001;
    for (int i = 0; i < 16; i++) begin
      press(10);
      if (i == 7) expect_led(10'h228, "wrap_mid");
    end
    expect_led(10'h030, "count_wrap");
    KEY[0] = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    KEY[0] = 1'b1;
    expect_led(10'h000, "reset_mid");
    tick(15);
    expect_led(10'h000, "no_late_update");
    tick(2);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending=%0d expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
